// File: rtl/operand_entry_if.sv
// operand_entry_if: switch/key inputs and operand/status outputs of operand_entry
interface operand_entry_if;
  logic [9:0] SW;
  logic [1:0] KEY;
  logic [3:0] X;
  logic [3:0] Y;
  logic       VALID;
  logic [1:0] STATE;
  logic [9:0] LED;
  modport master (output SW, KEY, input X, Y, VALID, STATE, LED);
  modport slave  (input SW, KEY, output X, Y, VALID, STATE, LED);
endinterface

// File: rtl/operand_entry.sv
// operand_entry: synchronize/debounce keys and capture two operands; OPERAND_ENTRY_DEBOUNCE_BYPASS_EN removes debounce
module operand_entry #(
  parameter int DEBOUNCE_CYCLES = 500000
) (
  input logic CLK,
  input logic RST_N,
  operand_entry_if.slave bus
);
  typedef enum logic [1:0] {ENTER_A = 2'b00, ENTER_B = 2'b01, SHOW = 2'b10} state_t;
  state_t st;
  logic [3:0] s1, s2, x, y;
  logic [1:0] k1, k2, stab, prev, press;
  logic valid;
  logic unused_sw;
  assign unused_sw = ^bus.SW[9:4];
  // two-flop synchronizers; keys idle released
  always_ff @(posedge CLK or negedge RST_N)
    if (!RST_N) begin
      s1 <= '0;
      s2 <= '0;
      k1 <= 2'b11;
      k2 <= 2'b11;
    end else begin
      s1 <= bus.SW[3:0];
      s2 <= s1;
      k1 <= bus.KEY;
      k2 <= k1;
    end
`ifdef OPERAND_ENTRY_DEBOUNCE_BYPASS_EN
  assign stab = k2;
`else
  localparam int CW = $clog2(DEBOUNCE_CYCLES);
  logic [CW-1:0] cnt [2];
  // accept a new key level only after DEBOUNCE_CYCLES consecutive differing samples
  always_ff @(posedge CLK or negedge RST_N)
    if (!RST_N) begin
      stab <= 2'b11;
      for (int i = 0; i < 2; i++) cnt[i] <= '0;
    end else
      for (int i = 0; i < 2; i++)
        if (k2[i] == stab[i]) cnt[i] <= '0;
        else if (cnt[i] == CW'(DEBOUNCE_CYCLES - 1)) begin
          stab[i] <= k2[i];
          cnt[i] <= '0;
        end else cnt[i] <= cnt[i] + 1'b1;
`endif
  // previous stable level, so a press is the cycle stable falls
  always_ff @(posedge CLK or negedge RST_N)
    if (!RST_N) prev <= 2'b11;
    else prev <= stab;
  assign press = prev & ~stab;
  // operand capture FSM; clear beats enter, illegal code recovers to ENTER_A
  always_ff @(posedge CLK or negedge RST_N)
    if (!RST_N) begin
      st <= ENTER_A;
      x <= '0;
      y <= '0;
      valid <= 1'b0;
    end else begin
      valid <= 1'b0;
      if (press[1]) begin
        st <= ENTER_A;
        x <= '0;
        y <= '0;
      end else
        case (st)
          ENTER_A: if (press[0]) begin
            x <= s2;
            st <= ENTER_B;
          end
          ENTER_B: if (press[0]) begin
            y <= s2;
            valid <= 1'b1;
            st <= SHOW;
          end
          SHOW: if (press[0]) begin
            x <= s2;
            st <= ENTER_B;
          end
          default: begin
            st <= ENTER_A;
            x <= '0;
            y <= '0;
          end
        endcase
    end
  assign bus.X = x;
  assign bus.Y = y;
  assign bus.VALID = valid;
  assign bus.STATE = st;
  assign bus.LED = {st == SHOW, st == ENTER_B, y, x};
endmodule

// File: tb/tb_operand_entry.sv
// tb_operand_entry: scoreboard bench for operand_entry with DEBOUNCE_CYCLES=4
module tb_operand_entry;
  logic CLK = 1'b0;
  logic RST_N = 1'b0;
  operand_entry_if bus ();
  operand_entry #(.DEBOUNCE_CYCLES(4)) dut (.CLK(CLK), .RST_N(RST_N), .bus(bus.slave));
  always #5 CLK = ~CLK;
  int checks = 0;
  int errors = 0;
  int valids = 0;
  logic [7:0] q[$];
  task automatic chk(input string name, input logic [9:0] act, input logic [9:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s act=%h exp=%h", name, act, exp);
    end
  endtask
  task automatic cyc(input int n);
    repeat (n) @(negedge CLK);
  endtask
  task automatic press(input logic [1:0] k);
    bus.KEY = ~k;
    cyc(10);
    bus.KEY = 2'b11;
    cyc(12);
  endtask
  always @(negedge CLK)
    if (RST_N && bus.VALID) begin
      logic [7:0] e;
      checks++;
      valids++;
      if (q.size() == 0) begin
        errors++;
        $display("FAIL valid_unexpected act=%h%h exp=none", bus.X, bus.Y);
      end else begin
        e = q.pop_front();
        if ({bus.X, bus.Y} !== e) begin
          errors++;
          $display("FAIL valid_pair act=%h%h exp=%h", bus.X, bus.Y, e);
        end
      end
    end
  initial begin
    bus.SW = 10'h3f0;
    bus.KEY = 2'b11;
    cyc(3);
    chk("rst_x", 10'(bus.X), 10'h0);
    chk("rst_y", 10'(bus.Y), 10'h0);
    chk("rst_valid", 10'(bus.VALID), 10'h0);
    chk("rst_state", 10'(bus.STATE), 10'h0);
    chk("rst_led", bus.LED, 10'h0);
    RST_N = 1'b1;
    cyc(3);
    for (int i = 0; i < 5; i++) begin
      bus.KEY = 2'b10;
      cyc(2);
      bus.KEY = 2'b11;
      cyc(6);
    end
    cyc(10);
    chk("glitch_state", 10'(bus.STATE), 10'h0);
    chk("glitch_x", 10'(bus.X), 10'h0);
    bus.SW = 10'h3f3;
    cyc(3);
    press(2'b01);
    chk("a_x", 10'(bus.X), 10'h3);
    chk("a_state", 10'(bus.STATE), 10'h1);
    chk("a_led", bus.LED, 10'b01_0000_0011);
    bus.SW = 10'h00a;
    cyc(3);
    q.push_back(8'h3a);
    press(2'b01);
    chk("b_y", 10'(bus.Y), 10'ha);
    chk("b_state", 10'(bus.STATE), 10'h2);
    chk("b_led", bus.LED, 10'b10_1010_0011);
    bus.SW = 10'h00f;
    cyc(3);
    press(2'b01);
    chk("re_x", 10'(bus.X), 10'hf);
    chk("re_y", 10'(bus.Y), 10'ha);
    chk("re_state", 10'(bus.STATE), 10'h1);
    bus.SW = 10'h001;
    cyc(3);
    q.push_back(8'hf1);
    press(2'b01);
    chk("re_y2", 10'(bus.Y), 10'h1);
    chk("re_state2", 10'(bus.STATE), 10'h2);
    bus.SW = 10'h005;
    cyc(3);
    press(2'b01);
    chk("pre_clr_x", 10'(bus.X), 10'h5);
    chk("pre_clr_state", 10'(bus.STATE), 10'h1);
    press(2'b11);
    chk("clr_x", 10'(bus.X), 10'h0);
    chk("clr_y", 10'(bus.Y), 10'h0);
    chk("clr_state", 10'(bus.STATE), 10'h0);
    bus.SW = 10'h003;
    cyc(3);
    press(2'b01);
    chk("mid_x", 10'(bus.X), 10'h3);
    bus.KEY = 2'b10;
    cyc(4);
    #2 RST_N = 1'b0;
    #1;
    chk("async_x", 10'(bus.X), 10'h0);
    chk("async_y", 10'(bus.Y), 10'h0);
    chk("async_valid", 10'(bus.VALID), 10'h0);
    chk("async_state", 10'(bus.STATE), 10'h0);
    chk("async_led", bus.LED, 10'h0);
    chk("valid_count", 10'(valids), 10'd2);
    chk("queue_left", 10'(q.size()), 10'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
